// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: two-stage pipelined carry-lookahead add/subtract unit with valid/ready on both sides.
//    Subtraction computes A + ~B + ~bin. Stage 1 adds the low half; stage 2 adds the high half
//    from the registered stage-1 carry.
//    clk       in   rising-edge clock
//    rst_n     in   asynchronous active-low reset
//    in_valid  in   operand beat valid          in_ready  out  unit can accept a beat
//    in_a      in   operand A                   in_b      in   operand B
//    in_cin    in   carry-in / borrow-in        in_op     in   0 = add, 1 = subtract
//    out_valid out  result beat valid           out_ready in   consumer accepts result
//    out_sum   out  result                      out_cout  out  carry-out (sub: 1 = no borrow)
//    out_ovf   out  signed overflow
module cla_addsub_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);
   localparam int L = WIDTH / 2;
   // Lookahead carries of one half: c[i+1] = g[i] | p[i]&c[i], flattened by synthesis.
   function automatic logic [L:0] cla_carry(input logic [L-1:0] a, input logic [L-1:0] b, input logic c0);
      logic [L:0] c;
      c[0] = c0;
      for (int i = 0; i < L; i++) c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
      return c;
   endfunction
   logic [WIDTH-1:0] b_eff, sum_q;
   logic             c0, s2_ready, accept, advance;
   logic [L:0]       c_lo, c_hi;
   logic [L-1:0]     sum_lo, sum_hi, s1_sum_q, s1_a_q, s1_b_q;
   logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s1_c_q, cout_q, ovf_q;
   assign s2_ready = !s2_valid_q | out_ready;
   assign in_ready = !s1_valid_q | s2_ready;
   assign accept   = in_valid & in_ready;
   assign advance  = s1_valid_q & s2_ready;
   assign out_valid = s2_valid_q;
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
   assign out_ovf   = ovf_q;
   always_comb begin
      b_eff      = in_op ? ~in_b : in_b;
      c0         = in_op ? ~in_cin : in_cin;
      c_lo       = cla_carry(in_a[L-1:0], b_eff[L-1:0], c0);
      sum_lo     = in_a[L-1:0] ^ b_eff[L-1:0] ^ c_lo[L-1:0];
      c_hi       = cla_carry(s1_a_q, s1_b_q, s1_c_q);
      sum_hi     = s1_a_q ^ s1_b_q ^ c_hi[L-1:0];
      s1_valid_d = accept ? 1'b1 : advance ? 1'b0 : s1_valid_q;
      s2_valid_d = advance ? 1'b1 : out_ready ? 1'b0 : s2_valid_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_sum_q   <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_c_q     <= 1'b0;
         sum_q      <= '0;
         cout_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         if (accept) begin
            s1_sum_q <= sum_lo;
            s1_c_q   <= c_lo[L];
            s1_a_q   <= in_a[WIDTH-1:L];
            s1_b_q   <= b_eff[WIDTH-1:L];
         end
         if (advance) begin
            sum_q  <= {sum_hi, s1_sum_q};
            cout_q <= c_hi[L];
            ovf_q  <= c_hi[L] ^ c_hi[L-1];
         end
      end
   end
endmodule
